// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length of each message.
module sha256_msg_padder #(
  parameter int IN_BYTES = 4,
  parameter int LEN_W    = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [8*IN_BYTES-1:0]     in_data_i,
  input  logic                      in_last_i,
  input  logic [$clog2(IN_BYTES):0] in_nbytes_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [511:0]              out_block_o,
  output logic                      out_last_o,
  output logic                      len_err_o
);

  localparam logic [1:0] S_ABSORB    = 2'd0;
  localparam logic [1:0] S_EMIT_DATA = 2'd1;
  localparam logic [1:0] S_EMIT_PAD1 = 2'd2;
  localparam logic [1:0] S_EMIT_PAD2 = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [6:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [63:0][7:0] block_q, block_d;
  logic             padPending_q, padPending_d;
  logic             outLast_q, outLast_d;
  logic             lenErr_q, lenErr_d;

  logic [6:0]       beatBytes;
  logic [6:0]       ptrSum;
  logic [LEN_W:0]   countSum;
  logic [63:0]      lenNow;
  logic [63:0]      lenHeld;

  // Byte count of the current beat and the pointer/bit count it would produce.
  always_comb begin
    beatBytes = 7'(IN_BYTES);
    if (in_last_i) begin
      beatBytes = (7'(in_nbytes_i) > 7'(IN_BYTES)) ? 7'(IN_BYTES) : 7'(in_nbytes_i);
    end
    ptrSum   = ptr_q + beatBytes;
    countSum = {1'b0, count_q} + (LEN_W+1)'({beatBytes, 3'b000});
    lenNow   = 64'(countSum[LEN_W-1:0]);
    lenHeld  = 64'(count_q);
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    block_d      = block_q;
    padPending_d = padPending_q;
    outLast_d    = outLast_q;
    lenErr_d     = lenErr_q;
    case (state_q)
      S_ABSORB: begin
        if (in_valid_i) begin
          for (int j = 0; j < IN_BYTES; j++) begin
            if (7'(j) < beatBytes) begin
              block_d[6'(7'd63 - ptr_q - 7'(j))] = in_data_i[8*(IN_BYTES-1-j) +: 8];
            end
          end
          ptr_d   = ptrSum;
          count_d = countSum[LEN_W-1:0];
          if (countSum[LEN_W]) begin
            lenErr_d = 1'b1;
          end
          if (!in_last_i) begin
            if (ptrSum == 7'd64) begin
              state_d      = S_EMIT_DATA;
              padPending_d = 1'b0;
              outLast_d    = 1'b0;
            end
          end else if (ptrSum <= 7'd55) begin
            block_d[6'(7'd63 - ptrSum)] = 8'h80;
            block_d[7:0]                = lenNow;
            state_d                     = S_EMIT_PAD2;
            outLast_d                   = 1'b1;
          end else if (ptrSum <= 7'd63) begin
            block_d[6'(7'd63 - ptrSum)] = 8'h80;
            state_d                     = S_EMIT_PAD1;
            outLast_d                   = 1'b0;
          end else begin
            state_d      = S_EMIT_DATA;
            padPending_d = 1'b1;
            outLast_d    = 1'b0;
          end
        end
      end
      // Every emitted block is wiped on handshake so later blocks never carry stale bytes.
      S_EMIT_DATA: begin
        if (out_ready_i) begin
          block_d = '0;
          if (padPending_q) begin
            block_d[63]   = 8'h80;
            block_d[7:0]  = lenHeld;
            state_d       = S_EMIT_PAD2;
            outLast_d     = 1'b1;
            padPending_d  = 1'b0;
          end else begin
            state_d = S_ABSORB;
            ptr_d   = '0;
          end
        end
      end
      S_EMIT_PAD1: begin
        if (out_ready_i) begin
          block_d      = '0;
          block_d[7:0] = lenHeld;
          state_d      = S_EMIT_PAD2;
          outLast_d    = 1'b1;
        end
      end
      S_EMIT_PAD2: begin
        if (out_ready_i) begin
          block_d   = '0;
          state_d   = S_ABSORB;
          ptr_d     = '0;
          count_d   = '0;
          outLast_d = 1'b0;
        end
      end
      default: begin
        state_d = S_ABSORB;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_ABSORB;
      ptr_q        <= '0;
      count_q      <= '0;
      block_q      <= '0;
      padPending_q <= 1'b0;
      outLast_q    <= 1'b0;
      lenErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      block_q      <= block_d;
      padPending_q <= padPending_d;
      outLast_q    <= outLast_d;
      lenErr_q     <= lenErr_d;
    end
  end

  assign in_ready_o  = (state_q == S_ABSORB) && !rst_i;
  assign out_valid_o = (state_q != S_ABSORB);
  assign out_block_o = block_q;
  assign out_last_o  = outLast_q;
  assign len_err_o   = lenErr_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: two instances (4-byte beats/64-bit length and
// 1-byte beats/8-bit length) driven with random messages against a FIPS padding model.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic rst;
  logic outReady;

  always #5 clk = ~clk;

  logic         aInValid, aInLast, aInReady, aOutValid, aOutLast, aLenErr;
  logic [31:0]  aInData;
  logic [2:0]   aInNbytes;
  logic [511:0] aOutBlock;

  logic         bInValid, bInLast, bInReady, bOutValid, bOutLast, bLenErr;
  logic [7:0]   bInData;
  logic [0:0]   bInNbytes;
  logic [511:0] bOutBlock;

  sha256_msg_padder #(.IN_BYTES(4), .LEN_W(64)) dutA (
    .clk_i(clk), .rst_i(rst), .in_valid_i(aInValid), .in_ready_o(aInReady),
    .in_data_i(aInData), .in_last_i(aInLast), .in_nbytes_i(aInNbytes),
    .out_valid_o(aOutValid), .out_ready_i(outReady), .out_block_o(aOutBlock),
    .out_last_o(aOutLast), .len_err_o(aLenErr)
  );

  sha256_msg_padder #(.IN_BYTES(1), .LEN_W(8)) dutB (
    .clk_i(clk), .rst_i(rst), .in_valid_i(bInValid), .in_ready_o(bInReady),
    .in_data_i(bInData), .in_last_i(bInLast), .in_nbytes_i(bInNbytes),
    .out_valid_o(bOutValid), .out_ready_i(outReady), .out_block_o(bOutBlock),
    .out_last_o(bOutLast), .len_err_o(bLenErr)
  );

  int           curSel;
  logic         curInReady, curOutValid, curOutLast, curLenErr;
  logic [511:0] curOutBlock;

  // Route the outputs of whichever instance is under test to one set of names.
  always_comb begin
    if (curSel == 0) begin
      curInReady  = aInReady;
      curOutValid = aOutValid;
      curOutLast  = aOutLast;
      curLenErr   = aLenErr;
      curOutBlock = aOutBlock;
    end else begin
      curInReady  = bInReady;
      curOutValid = bOutValid;
      curOutLast  = bOutLast;
      curLenErr   = bLenErr;
      curOutBlock = bOutBlock;
    end
  end

  int           errors = 0;
  int           checks = 0;
  byte unsigned msgQ[$];
  logic [511:0] expBlk[$];
  logic         expLast[$];
  logic         expErr[2];
  int           stallLeft;

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, length (mod 2^lenW) big-endian.
  task automatic buildExpected(input int sel);
    int              lenW;
    byte unsigned    padded[$];
    longint unsigned bits;
    logic [63:0]     lenField;
    logic [511:0]    v;
    int              nBlk;
    lenW = (sel == 0) ? 64 : 8;
    padded = msgQ;
    padded.push_back(8'h80);
    while (padded.size() % 64 != 56) padded.push_back(8'h00);
    bits = longint'(msgQ.size()) * 8;
    if (lenW < 64) begin
      if (bits >= (64'd1 << lenW)) expErr[sel] = 1'b1;
      lenField = bits & ((64'd1 << lenW) - 64'd1);
    end else begin
      lenField = bits;
    end
    for (int i = 0; i < 8; i++) padded.push_back(lenField[63-8*i -: 8]);
    expBlk.delete();
    expLast.delete();
    nBlk = padded.size() / 64;
    for (int b = 0; b < nBlk; b++) begin
      for (int i = 0; i < 64; i++) v[511-8*i -: 8] = padded[64*b+i];
      expBlk.push_back(v);
      expLast.push_back(b == nBlk - 1);
    end
  endtask

  task automatic loadString(input string s);
    msgQ.delete();
    for (int i = 0; i < s.len(); i++) msgQ.push_back(s[i]);
  endtask

  task automatic loadRandom(input int n);
    msgQ.delete();
    for (int i = 0; i < n; i++) msgQ.push_back(8'($urandom));
  endtask

  // Drive one beat at a negedge, hold until accepted, then check the one-cycle latency.
  task automatic driveBeat(input int sel, input int pos, input int n, input bit last);
    logic [31:0] d;
    int          t;
    bit          completes;
    d = $urandom;
    for (int j = 0; j < 4; j++) if (j < n) d[31-8*j -: 8] = msgQ[pos+j];
    if (sel == 0) begin
      aInData = d; aInLast = last; aInNbytes = 3'(n); aInValid = 1'b1;
    end else begin
      bInData = (n > 0) ? msgQ[pos] : 8'($urandom); bInLast = last;
      bInNbytes = 1'(n); bInValid = 1'b1;
    end
    t = 0;
    while (!curInReady && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!curInReady) begin
      checkOutput("inReadyTimeout", 512'(curInReady), 512'(1));
      aInValid = 1'b0; bInValid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    aInValid = 1'b0; bInValid = 1'b0;
    completes = last || ((pos + n) % 64 == 0);
    checkOutput("outValidLatency", 512'(curOutValid), 512'(completes));
  endtask

  task automatic applyStimulus(input int sel);
    int nb, total, pos, rem, n;
    bit last, emptyTail;
    nb = (sel == 0) ? 4 : 1;
    total = msgQ.size();
    pos = 0;
    emptyTail = (total % nb == 0) && ($urandom_range(0, 2) == 0);
    forever begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rem = total - pos;
      if (emptyTail) begin
        last = (rem == 0);
        n = last ? 0 : nb;
      end else begin
        last = (rem <= nb);
        n = last ? rem : nb;
      end
      driveBeat(sel, pos, n, last);
      pos += n;
      if (last) break;
    end
  endtask

  task automatic consumeBlocks();
    int k, t;
    bit r;
    k = 0;
    t = 0;
    while (k < expBlk.size() && t < 3000) begin
      @(negedge clk);
      t++;
      if (curOutValid && stallLeft > 0) begin
        outReady = 1'b0;
        checkOutput("stallBlock", curOutBlock, expBlk[k]);
        checkOutput("stallLast", 512'(curOutLast), 512'(expLast[k]));
        checkOutput("stallInReady", 512'(curInReady), 512'(0));
        stallLeft--;
        continue;
      end
      r = ($urandom_range(0, 3) != 0);
      outReady = r;
      if (curOutValid && r) begin
        checkOutput($sformatf("block%0d", k), curOutBlock, expBlk[k]);
        checkOutput($sformatf("last%0d", k), 512'(curOutLast), 512'(expLast[k]));
        k++;
      end
    end
    @(negedge clk);
    outReady = 1'b0;
    if (k < expBlk.size()) checkOutput("blockCount", 512'(k), 512'(expBlk.size()));
    checkOutput("outValidDrop", 512'(curOutValid), 512'(0));
  endtask

  task automatic runMessage(input int sel);
    buildExpected(sel);
    curSel = sel;
    fork
      applyStimulus(sel);
      consumeBlocks();
    join
    @(negedge clk);
    checkOutput("lenErr", 512'(curLenErr), 512'(expErr[sel]));
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1; outReady = 1'b0; aInValid = 1'b0; bInValid = 1'b0;
    @(negedge clk);
    checkOutput("rstValidA", 512'(aOutValid), 512'(0));
    checkOutput("rstReadyA", 512'(aInReady), 512'(0));
    checkOutput("rstBlockA", aOutBlock, 512'(0));
    checkOutput("rstLastA", 512'(aOutLast), 512'(0));
    checkOutput("rstErrA", 512'(aLenErr), 512'(0));
    checkOutput("rstValidB", 512'(bOutValid), 512'(0));
    checkOutput("rstReadyB", 512'(bInReady), 512'(0));
    checkOutput("rstBlockB", bOutBlock, 512'(0));
    checkOutput("rstErrB", 512'(bLenErr), 512'(0));
    rst = 1'b0;
    expErr[0] = 1'b0;
    expErr[1] = 1'b0;
    @(negedge clk);
    checkOutput("postRstReadyA", 512'(aInReady), 512'(1));
    checkOutput("postRstReadyB", 512'(bInReady), 512'(1));
  endtask

  initial begin
    rst = 1'b1; outReady = 1'b0; curSel = 0; stallLeft = 0;
    aInValid = 1'b0; aInLast = 1'b0; aInData = '0; aInNbytes = '0;
    bInValid = 1'b0; bInLast = 1'b0; bInData = '0; bInNbytes = '0;
    expErr[0] = 1'b0; expErr[1] = 1'b0;
    resetDut();

    $display("[TB] abc and empty messages");
    loadString("abc"); runMessage(1);
    msgQ.delete();     runMessage(1);
    msgQ.delete();     runMessage(0);

    $display("[TB] block boundary lengths");
    loadRandom(55);  runMessage(0);
    loadRandom(56);  runMessage(0);
    loadRandom(63);  runMessage(0);
    loadRandom(64);  runMessage(0);
    loadRandom(120); runMessage(0);
    loadRandom(64);  runMessage(1);

    $display("[TB] backpressure hold");
    loadString("abcdef"); stallLeft = 10; runMessage(0);
    stallLeft = 0;

    $display("[TB] reset mid-message");
    loadRandom(30);
    curSel = 1;
    for (int i = 0; i < 30; i++) driveBeat(1, i, 1, 1'b0);
    resetDut();
    loadString("abc"); runMessage(1);

    $display("[TB] length overflow");
    loadRandom(32); runMessage(1);
    loadString("abc"); runMessage(1);
    resetDut();

    $display("[TB] random messages");
    for (int m = 0; m < 12; m++) begin
      loadRandom($urandom_range(0, 140));
      runMessage(m % 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
